// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and helpers for the FIFO write-port arbiter.
//               Holds the arbiter state encoding, the default grant-index
//               width, the default beat type, and the round-robin index
//               helper used by the priority selector.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int DATA_W_DEFAULT  = 80;
    localparam int GRANT_W         = $clog2(NUM_REQ_DEFAULT);

    typedef logic [DATA_W_DEFAULT-1:0] beat_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index visited 'step' positions after 'ptr' on a ring of n requesters.
    function automatic int unsigned rr_index(input int unsigned ptr,
                                             input int unsigned step,
                                             input int unsigned n);
        return (ptr + step) % n;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority selector. Scans the
//               request vector starting one position after rr_ptr_i and
//               wrapping modulo NUM_REQ; the first set bit wins.
// Ports       : req_i       - request vector
//               rr_ptr_i    - index of the most recent winner
//               winner_o    - selected index (0 when nothing is requesting)
//               any_valid_o - at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      rr_ptr_i,
    output logic [GW-1:0]      winner_o,
    output logic               any_valid_o
);

    int unsigned w_idx;

    // Walk the ring from the farthest position back to the nearest so the
    // last overwrite is the closest set bit after rr_ptr_i.
    always_comb begin
        winner_o    = '0;
        any_valid_o = |req_i;
        w_idx       = 0;
        for (int step = NUM_REQ; step >= 1; step--) begin
            w_idx = rr_index(32'(rr_ptr_i), 32'(step), 32'(NUM_REQ));
            if (req_i[w_idx]) begin
                winner_o = GW'(w_idx);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Shares the write port of an async FIFO among NUM_REQ
//               requesters, in the FIFO write-clock domain. Round-robin
//               arbitration with packet lock: a granted requester keeps the
//               port until it delivers a last beat or MAX_BURST beats.
// Ports       : write_clk      - write-domain clock, rising edge
//               rst            - synchronous active-high reset
//               req_valid/last - per-requester beat valid / last marker
//               req_data       - packed beats, requester i at [i*DATA_W +: DATA_W]
//               req_ready      - per-requester beat accepted when valid
//               fifo_full      - FIFO full flag (authoritative)
//               fifo_write_en  - FIFO write strobe
//               fifo_data_in   - FIFO write data
//               grant_id       - current or last granted requester
//               busy           - high while a requester holds the port
//               burst_overrun  - sticky: a grant was force-released
//               pkt_count      - number of last beats written (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 80,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic                        write_clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_write_en,
    output logic [DATA_W-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        burst_overrun,
    output logic [CNT_W-1:0]            pkt_count
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    localparam logic [GW-1:0]  c_last_req  = GW'(NUM_REQ - 1);
    localparam logic [BCW:0]   c_max_burst = (BCW + 1)'(MAX_BURST);

    arb_state_e         state_q,    state_d;
    logic [GW-1:0]      grant_q,    grant_d;
    logic [GW-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    logic               overrun_q,  overrun_d;
    logic [CNT_W-1:0]   pkt_cnt_q,  pkt_cnt_d;

    logic               w_busy;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_accept;
    logic [BCW:0]       w_beat_next;
    logic               w_cap_hit;
    logic [GW-1:0]      w_winner;
    logic               w_any_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (w_winner),
        .any_valid_o (w_any_valid)
    );

    assign w_busy      = (state_q == GRANT);
    assign w_sel_valid = req_valid[grant_q];
    assign w_sel_last  = req_last[grant_q];
    assign w_sel_data  = req_data[int'(grant_q)*DATA_W +: DATA_W];

    // Full is honoured combinationally: no beat is taken while it is high.
    assign w_accept    = w_busy && w_sel_valid && !fifo_full;

    // One extra bit so MAX_BURST itself is representable in the compare.
    assign w_beat_next = {1'b0, beat_cnt_q} + 1'b1;
    assign w_cap_hit   = (w_beat_next == c_max_burst);

    always_comb begin
        req_ready = '0;
        if (w_busy && !fifo_full) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // Data is a straight passthrough of the granted slice; zero when idle.
    assign fifo_write_en = w_accept;
    assign fifo_data_in  = w_busy ? w_sel_data : '0;
    assign grant_id      = grant_q;
    assign busy          = w_busy;
    assign burst_overrun = overrun_q;
    assign pkt_count     = pkt_cnt_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        overrun_d  = overrun_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_any_valid) begin
                    grant_d    = w_winner;
                    rr_ptr_d   = w_winner;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (w_accept) begin
                    if (w_sel_last) begin
                        // A last beat on the capped beat is a normal completion.
                        pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else if (w_cap_hit) begin
                        overrun_d  = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = w_beat_next[BCW-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= c_last_req;
            beat_cnt_q <= '0;
            overrun_q  <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

endmodule : fifo_write_arbiter
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed self-checking bench for fifo_write_arbiter with
//               NUM_REQ=4, DATA_W=80, MAX_BURST=4, CNT_W=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 80;
    localparam int MB = 4;
    localparam int CW = 16;

    logic               write_clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR*DW-1:0]   req_data = '0;
    logic [NR-1:0]      req_last = '0;
    logic [NR-1:0]      req_ready;
    logic               fifo_full = 1'b0;
    logic               fifo_write_en;
    logic [DW-1:0]      fifo_data_in;
    logic [1:0]         grant_id;
    logic               busy;
    logic               burst_overrun;
    logic [CW-1:0]      pkt_count;

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .CNT_W     (CW)
    ) u_dut (
        .write_clk     (write_clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .grant_id      (grant_id),
        .busy          (busy),
        .burst_overrun (burst_overrun),
        .pkt_count     (pkt_count)
    );

    always #5 write_clk = ~write_clk;

    task automatic chk(input string tag, input beat_t obs, input beat_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge write_clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input beat_t d, input logic l);
        req_valid[i]         = v;
        req_data[i*DW +: DW] = d;
        req_last[i]          = l;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state + single requester ----------------
        do_reset;
        settle;
        chk("rst_we",    fifo_write_en, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_pkt",   pkt_count, 0);
        chk("rst_ovr",   burst_overrun, 0);
        chk("rst_data",  fifo_data_in, 0);

        set_req(0, 1'b1, 'hA1, 1'b0);
        settle;
        chk("s1_idle_we",    fifo_write_en, 0);
        chk("s1_idle_ready", req_ready, 0);
        tick;
        chk("s1_grant", grant_id, 0);
        chk("s1_busy",  busy, 1);
        chk("s1_we1",   fifo_write_en, 1);
        chk("s1_d1",    fifo_data_in, 'hA1);
        tick;
        set_req(0, 1'b1, 'hA2, 1'b0);
        settle;
        chk("s1_we2", fifo_write_en, 1);
        chk("s1_d2",  fifo_data_in, 'hA2);
        tick;
        set_req(0, 1'b1, 'hA3, 1'b1);
        settle;
        chk("s1_we3", fifo_write_en, 1);
        chk("s1_d3",  fifo_data_in, 'hA3);
        tick;
        set_req(0, 1'b0, 0, 1'b0);
        settle;
        chk("s1_busy_end", busy, 0);
        chk("s1_pkt",      pkt_count, 1);
        chk("s1_we_end",   fifo_write_en, 0);

        // ---------------- round-robin with 1-beat packets ----------------
        do_reset;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, beat_t'('hB0 + i), 1'b1);
        settle;
        for (int k = 0; k < 6; k++) begin
            chk("rr_bubble_we",   fifo_write_en, 0);
            chk("rr_bubble_busy", busy, 0);
            tick;
            chk("rr_grant", grant_id, beat_t'(k % 4));
            chk("rr_we",    fifo_write_en, 1);
            chk("rr_data",  fifo_data_in, beat_t'('hB0 + (k % 4)));
            tick;
        end
        chk("rr_pkt", pkt_count, 6);
        req_valid = '0;

        // ---------------- backpressure on requester 2 ----------------
        do_reset;
        set_req(2, 1'b1, 'hC1, 1'b0);
        settle;
        tick;
        chk("bp_grant", grant_id, 2);
        chk("bp_we1",   fifo_write_en, 1);
        chk("bp_d1",    fifo_data_in, 'hC1);
        tick;
        set_req(2, 1'b1, 'hC2, 1'b0);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle;
            chk("bp_full_ready", req_ready, 0);
            chk("bp_full_we",    fifo_write_en, 0);
            chk("bp_full_busy",  busy, 1);
            chk("bp_full_data",  fifo_data_in, 'hC2);
            tick;
        end
        fifo_full = 1'b0;
        settle;
        chk("bp_ready", req_ready, 4'b0100);
        chk("bp_we2",   fifo_write_en, 1);
        chk("bp_d2",    fifo_data_in, 'hC2);
        tick;
        set_req(2, 1'b1, 'hC3, 1'b1);
        settle;
        chk("bp_we3", fifo_write_en, 1);
        chk("bp_d3",  fifo_data_in, 'hC3);
        tick;
        set_req(2, 1'b0, 0, 1'b0);
        settle;
        chk("bp_pkt",  pkt_count, 1);
        chk("bp_busy", busy, 0);

        // ---------------- burst cap with competing requester ----------------
        do_reset;
        set_req(1, 1'b1, 'hD1, 1'b0);
        set_req(3, 1'b1, 'hE0, 1'b1);
        settle;
        tick;
        for (int b = 1; b <= 4; b++) begin
            set_req(1, 1'b1, beat_t'('hD0 + b), 1'b0);
            settle;
            chk("cap_grant", grant_id, 1);
            chk("cap_we",    fifo_write_en, 1);
            chk("cap_data",  fifo_data_in, beat_t'('hD0 + b));
            tick;
        end
        set_req(1, 1'b1, 'hD5, 1'b0);
        settle;
        chk("cap_rel_busy", busy, 0);
        chk("cap_ovr",      burst_overrun, 1);
        chk("cap_pkt0",     pkt_count, 0);
        tick;
        chk("cap_g3",    grant_id, 3);
        chk("cap_g3_we", fifo_write_en, 1);
        chk("cap_g3_d",  fifo_data_in, 'hE0);
        tick;
        set_req(3, 1'b0, 0, 1'b0);
        settle;
        chk("cap_pkt1",  pkt_count, 1);
        chk("cap_idle",  busy, 0);
        tick;
        chk("cap_g1b",  grant_id, 1);
        chk("cap_d5",   fifo_data_in, 'hD5);
        chk("cap_we5",  fifo_write_en, 1);
        tick;
        set_req(1, 1'b1, 'hD6, 1'b1);
        settle;
        chk("cap_d6",  fifo_data_in, 'hD6);
        chk("cap_we6", fifo_write_en, 1);
        tick;
        set_req(1, 1'b0, 0, 1'b0);
        settle;
        chk("cap_pkt2",       pkt_count, 2);
        chk("cap_end_busy",   busy, 0);
        chk("cap_ovr_sticky", burst_overrun, 1);

        // ---------------- last beat on the capped beat ----------------
        do_reset;
        set_req(0, 1'b1, 'hF1, 1'b0);
        settle;
        tick;
        for (int b = 1; b <= 4; b++) begin
            set_req(0, 1'b1, beat_t'('hF0 + b), (b == 4));
            settle;
            chk("loc_we",   fifo_write_en, 1);
            chk("loc_data", fifo_data_in, beat_t'('hF0 + b));
            tick;
        end
        set_req(0, 1'b0, 0, 1'b0);
        settle;
        chk("loc_ovr",  burst_overrun, 0);
        chk("loc_pkt",  pkt_count, 1);
        chk("loc_busy", busy, 0);

        // ---------------- reset mid-packet ----------------
        do_reset;
        set_req(0, 1'b1, 'h91, 1'b0);
        settle;
        tick;
        for (int b = 1; b <= 2; b++) begin
            set_req(0, 1'b1, beat_t'('h90 + b), 1'b0);
            settle;
            chk("mr_we", fifo_write_en, 1);
            tick;
        end
        set_req(0, 1'b1, 'h93, 1'b0);
        rst = 1'b1;
        tick;
        chk("mr_we_rst",    fifo_write_en, 0);
        chk("mr_busy_rst",  busy, 0);
        chk("mr_pkt_rst",   pkt_count, 0);
        chk("mr_ready_rst", req_ready, 0);
        set_req(0, 1'b0, 0, 1'b0);
        set_req(1, 1'b1, 'h71, 1'b1);
        set_req(3, 1'b1, 'h73, 1'b1);
        rst = 1'b0;
        settle;
        chk("mr_idle_we", fifo_write_en, 0);
        tick;
        chk("mr_grant", grant_id, 1);
        chk("mr_data",  fifo_data_in, 'h71);
        chk("mr_we2",   fifo_write_en, 1);
        tick;
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_write_arbiter
`default_nettype wire
